shift_register: RTL and testbench
=================================

// Module: shift_register
// PURPOSE
//   Registered one-position bidirectional shifter of a parallel input word.
//   Each enabled cycle, data_in is shifted one bit left or right and the result is
//   captured in the output register. When not enabled, the output register holds.
//   Used as a generic datapath alignment stage; one clock domain, no handshake.
// PARAMETERS
//   WIDTH  8  data word width in bits (legal: >= 2)
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   enable     in   1      1 = capture shifted data_in this edge; 0 = hold
//   direction  in   1      0 = shift left (toward MSB); 1 = shift right (toward LSB)
//   data_in    in   WIDTH  parallel word to be shifted
//   data_out   out  WIDTH  registered shift result
// BEHAVIOUR
//   - One clock, clk rising edge. Reset is asynchronous and active-high.
//     Reset assertion sets data_out = 0 immediately, independent of clk.
//     data_out stays 0 while reset is high. The first capture is the first rising
//     edge after deassertion.
//   - data_out is registered only; there is no combinational path from inputs to data_out.
//   - Latency: one cycle. The value sampled at edge N appears on data_out after edge N.
//   - enable=1, direction=0: data_out <= {data_in[WIDTH-2:0], fill}, fill = 0.
//   - enable=1, direction=1: data_out <= {fill, data_in[WIDTH-1:1]}, fill = 0.
//   - enable=0: data_out holds its value; direction and data_in are ignored.
//   - The shift always operates on data_in, not on data_out, so repeated enabled
//     cycles with a constant data_in give a constant data_out.
//   - Bit shifted out of the word (data_in[WIDTH-1] left, data_in[0] right) is discarded.
//   - A direction change takes effect on the very next enabled edge; there is no pipeline flush.
//   - Reset asserted mid-stream: data_out = 0 at once. Stimulus during reset is ignored.
//   - X on enable or direction while reset is low is a usage error; no recovery is required.
// CONFIGURATION
//   Macro SHIFT_REGISTER_ROTATE_EN:
//   - Defined: rotate mode. The vacated bit takes the bit shifted out.
//     left fill = data_in[WIDTH-1]; right fill = data_in[0].
//   - Undefined (default build): logical shift; fill = 0 as specified above.
//   - The port list and latency are identical in both builds.
// STRUCTURE
//   - Package shift_register_pkg holds:
//     - localparam DEFAULT_WIDTH = 8
//     - typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} shift_dir_e
//   - Sub-module shift_register_core: purely combinational one-bit shifter.
//     Inputs: word, dir. Output: shifted word. It holds the rotate/fill selection
//     under SHIFT_REGISTER_ROTATE_EN.
//   - Top level: the core plus the enable-gated output register with async reset.
// TESTING
//   1. Hold reset=1 for 10 ns -> data_out = 8'h00. Also check mid-cycle: asserting
//      reset between edges clears data_out before the next edge.
//   2. enable=1, direction=1, data_in=8'hAA for 5 cycles -> data_out = 8'h55 after
//      the first edge and stays 8'h55 (rotate build: 8'h55 as well).
//   3. enable=1, direction=0, data_in=8'hAA -> data_out = 8'h54.
//      Rotate build -> 8'h55.
//   4. Capture 8'h81 right (8'h40), then enable=0 while data_in/direction toggle for
//      4 cycles -> data_out stays 8'h40. Rotate build -> 8'hC0 held.
//   5. Alternate direction every cycle with data_in=8'h01 -> 8'h02, 8'h00, 8'h02, ...
//      Rotate build -> 8'h02, 8'h80, 8'h02, ...
//   6. With enable=1 and data_out nonzero, pulse reset asynchronously -> data_out = 8'h00
//      at once. Release -> the next edge loads the shifted data_in.

Source files
------------

// File: rtl/shift_register_pkg.sv
// -----------------------------------------------------------------------------
// shift_register_pkg
//   Shared definitions for the shift_register block.
//   - DEFAULT_WIDTH : default data word width in bits
//   - shift_dir_e   : shift direction encoding (left = toward MSB, right = toward LSB)
// -----------------------------------------------------------------------------
package shift_register_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } shift_dir_e;

endpackage : shift_register_pkg

// File: rtl/shift_register_core.sv
// -----------------------------------------------------------------------------
// shift_register_core
//   Purely combinational one-position shifter.
//   Build option: SHIFT_REGISTER_ROTATE_EN
//     defined   -> rotate (the vacated bit takes the bit shifted out)
//     undefined -> logical shift (the vacated bit is 0)
// Ports:
//   word    in   WIDTH  word to be shifted
//   dir     in   1      DIR_LEFT (toward MSB) / DIR_RIGHT (toward LSB)
//   shifted out  WIDTH  word shifted by one position
// -----------------------------------------------------------------------------
module shift_register_core
    import shift_register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH   // legal: >= 2
) (
    input  logic [WIDTH-1:0] word,
    input  shift_dir_e       dir,
    output logic [WIDTH-1:0] shifted
);

    logic fill_left;    // bit entering at the LSB on a left shift
    logic fill_right;   // bit entering at the MSB on a right shift

`ifdef SHIFT_REGISTER_ROTATE_EN
    assign fill_left  = word[WIDTH-1];
    assign fill_right = word[0];
`else
    assign fill_left  = 1'b0;
    assign fill_right = 1'b0;
`endif

    always_comb begin
        // NOTE: default assignment first, so every path drives shifted and no latch is inferred.
        shifted = '0;
        unique case (dir)
            DIR_LEFT:  shifted = {word[WIDTH-2:0], fill_left};
            DIR_RIGHT: shifted = {fill_right, word[WIDTH-1:1]};
        endcase
    end

endmodule : shift_register_core

// File: rtl/shift_register.sv
// -----------------------------------------------------------------------------
// shift_register
//   Registered one-position bidirectional shifter of a parallel input word.
//   Each enabled cycle data_in is shifted one bit and captured in data_out;
//   otherwise data_out holds. The shift always works on data_in, never on
//   data_out. Latency is one cycle; data_out is purely registered.
//   Build option: SHIFT_REGISTER_ROTATE_EN (rotate instead of zero fill).
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset (clears data_out)
//   enable     in   1      1 = capture shifted data_in this edge, 0 = hold
//   direction  in   1      0 = shift left (toward MSB), 1 = shift right
//   data_in    in   WIDTH  parallel word to be shifted
//   data_out   out  WIDTH  registered shift result
// -----------------------------------------------------------------------------
module shift_register
    import shift_register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH   // legal: >= 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             direction,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] shifted;

    shift_register_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .word    (data_in),
        .dir     (shift_dir_e'(direction)),
        .shifted (shifted)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
        end else if (enable) begin
            data_out <= shifted;
        end
    end

endmodule : shift_register

// File: tb/tb_shift_register.sv
// -----------------------------------------------------------------------------
// tb_shift_register
//   Self-checking bench for shift_register (WIDTH = 8). Directed steps followed
//   by randomized steps, all compared against a reference model built from
//   shift/rotate arithmetic. Follows the build option SHIFT_REGISTER_ROTATE_EN.
// -----------------------------------------------------------------------------
module tb_shift_register;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         direction;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;

    int           n_checks;
    int           n_fails;
    logic [W-1:0] model_q;

    shift_register #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .direction (direction),
        .data_in   (data_in),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what one enabled edge should capture for a given word/direction.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] w, input logic dir);
        logic [W-1:0] r;
        if (dir) begin
            r = w >> 1;
`ifdef SHIFT_REGISTER_ROTATE_EN
            r = r | (w << (W - 1));
`endif
        end else begin
            r = w << 1;
`ifdef SHIFT_REGISTER_ROTATE_EN
            r = r | (w >> (W - 1));
`endif
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] expected);
        n_checks++;
        assert (data_out === expected)
        else begin
            n_fails++;
            $error("FAIL %s: data_out=%h expected=%h", tag, data_out, expected);
        end
    endtask

    // One clock: drive on the falling edge, update the model, check #1 after the rising edge.
    task automatic step(input string tag, input logic en, input logic dir, input logic [W-1:0] din);
        @(negedge clk);
        enable    = en;
        direction = dir;
        data_in   = din;
        @(posedge clk);
        if (en) model_q = ref_shift(din, dir);
        #1;
        check(tag, model_q);
    endtask

    // Asynchronous reset pulse between edges, inputs unchanged; then check the next capture.
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        model_q = '0;
        check({tag, "_async_clear"}, model_q);
        #1 reset = 1'b0;
        @(posedge clk);
        if (enable) model_q = ref_shift(data_in, direction);
        #1;
        check({tag, "_first_after_release"}, model_q);
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        model_q   = '0;
        reset     = 1'b1;
        enable    = 1'b1;
        direction = 1'b1;
        data_in   = 8'hAA;

        // 1. Reset held for 10 ns, including a rising edge with enable high.
        #3 check("reset_before_edge", 8'h00);
        #5 check("reset_after_edge", 8'h00);
        #2 reset = 1'b0;

        // 2. Right shift of AA, repeated: constant output.
        for (int i = 0; i < 5; i++) step("right_AA", 1'b1, 1'b1, 8'hAA);

        // 3. Left shift of AA.
        step("left_AA", 1'b1, 1'b0, 8'hAA);
        step("left_AA_again", 1'b1, 1'b0, 8'hAA);

        // Mid-cycle reset clears output before the next edge.
        reset_pulse("mid_cycle");

        // 4. Capture 81 right, then hold while inputs toggle.
        step("right_81", 1'b1, 1'b1, 8'h81);
        for (int i = 0; i < 4; i++)
            step("hold", 1'b0, 1'(i), (i % 2 == 0) ? 8'hFF : 8'h3C);

        // 5. Alternate direction each cycle with data_in = 01.
        for (int i = 0; i < 6; i++) step("alt_dir_01", 1'b1, 1'(i), 8'h01);

        // Boundary words: MSB/LSB only, all ones.
        step("left_80", 1'b1, 1'b0, 8'h80);
        step("right_01", 1'b1, 1'b1, 8'h01);
        step("left_FF", 1'b1, 1'b0, 8'hFF);
        step("right_FF", 1'b1, 1'b1, 8'hFF);

        // 6. Reset pulse with enable high and data_out nonzero.
        step("preload_C3", 1'b1, 1'b0, 8'hC3);
        reset_pulse("enabled_pulse");

        // Randomized steps with occasional asynchronous reset pulses.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                reset_pulse("rand_reset");
            end else begin
                step("random", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     W'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_shift_register
